mdu_stall_ctrl: RTL and testbench

- Execute-stage sequencer for multi-cycle RV32M ops (MUL/MULH/MULHU/MULHSU/DIV/DIVU/REM/REMU) issued to the ALU.
- The ALU's multiplier and divider are clock-pipelined cores, so their result is valid only a fixed number of cycles after the operands are applied.
- This block detects M-ops from aluop, stalls the ID/EX register so operands stay stable, and releases the stall exactly when the ALU result is valid for the EX/MEM register.
- Sits between the hazard unit and the EX/MEM register; also keeps a stall-cycle performance counter.

---
 rtl/mdu_stall_ctrl.sv | 158 +++++++++++++++
 tb/tb_mdu_stall_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_stall_ctrl.sv
// Execute-stage sequencer for multi-cycle RV32M ops: holds ID/EX until the
// pipelined multiplier/divider result is valid, and counts stall cycles.
module mdu_stall_ctrl #(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = 4
) (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic        ex_valid,
  input  logic [4:0]  aluop,
  input  logic        flush,
  output logic        stall,
  output logic        mdu_done,
  output logic        busy,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter preload is LAT-2; a latency of 1 skips WAIT entirely.
  localparam int MUL_PRE_I = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
  localparam int DIV_PRE_I = (DIV_LATENCY > 1) ? DIV_LATENCY - 2 : 0;
  localparam logic [CNT_W-1:0] MUL_PRE = CNT_W'(MUL_PRE_I);
  localparam logic [CNT_W-1:0] DIV_PRE = CNT_W'(DIV_PRE_I);

  state_t            state_r, next_state_s;
  logic [CNT_W-1:0]  cnt_r, next_cnt_s;
  logic              lat_sel_r, next_lat_sel_s;
  logic [31:0]       perf_stall_cnt_r;
  logic              is_mul_s, is_div_s, start_s, lat_one_s;
  logic              stall_s, done_s;

  assign is_mul_s  = (aluop >= 5'd10) && (aluop <= 5'd13);
  assign is_div_s  = (aluop >= 5'd14) && (aluop <= 5'd17);
  assign start_s   = ex_valid && (is_mul_s || is_div_s) && !flush;
  assign lat_one_s = is_div_s ? (DIV_LATENCY == 1) : (MUL_LATENCY == 1);

  // Sequencer state, latency counter and latency select registers
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      lat_sel_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= next_cnt_s;
      lat_sel_r <= next_lat_sel_s;
    end
  end

  // Next-state, stall and done decode; flush overrides every transition
  always_comb begin
    next_state_s   = state_r;
    next_cnt_s     = cnt_r;
    next_lat_sel_s = lat_sel_r;
    stall_s        = 1'b0;
    done_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          stall_s        = 1'b1;
          next_lat_sel_s = is_div_s;
          if (lat_one_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_WAIT;
            next_cnt_s   = is_div_s ? DIV_PRE : MUL_PRE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          next_state_s = ST_IDLE;
        end else begin
          stall_s = 1'b1;
          if (cnt_r == {CNT_W{1'b0}}) begin
            next_state_s = ST_DONE;
          end else begin
            next_cnt_s = cnt_r - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        // ex_valid/aluop still describe the completing op here
        next_state_s = ST_IDLE;
        if (flush) begin
          done_s = 1'b0;
        end else begin
          done_s = 1'b1;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Stall-cycle performance counter, wraps modulo 2^32
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      perf_stall_cnt_r <= 32'd0;
    end else if (stall_s) begin
      perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
    end else begin
      perf_stall_cnt_r <= perf_stall_cnt_r;
    end
  end

  assign stall          = stall_s;
  assign mdu_done       = done_s;
  assign busy           = (state_r != ST_IDLE);
  assign perf_stall_cnt = perf_stall_cnt_r;

  mdu_stall_ctrl_chk #(
    .CNT_W   (CNT_W),
    .MUL_PRE (MUL_PRE),
    .DIV_PRE (DIV_PRE)
  ) u_chk (
    .clk     (ACLK),
    .rst     (RESET),
    .in_wait (state_r == ST_WAIT),
    .flush   (flush),
    .aluop   (aluop),
    .cnt     (cnt_r),
    .lat_sel (lat_sel_r)
  );

endmodule

// Run-time checks on the upstream stability contract and counter range.
module mdu_stall_ctrl_chk #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] MUL_PRE = '0,
  parameter logic [CNT_W-1:0] DIV_PRE = '0
) (
  input logic             clk,
  input logic             rst,
  input logic             in_wait,
  input logic             flush,
  input logic [4:0]       aluop,
  input logic [CNT_W-1:0] cnt,
  input logic             lat_sel
);

  a_aluop_stable: assert property (@(posedge clk) disable iff (rst)
    (in_wait && !flush) |-> $stable(aluop));

  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    in_wait |-> (cnt <= (lat_sel ? DIV_PRE : MUL_PRE)));

endmodule

// File: tb/tb_mdu_stall_ctrl.sv
// Directed bench for mdu_stall_ctrl: default build plus a MUL_LATENCY=1 build.
module tb_mdu_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev, fl;
  logic [4:0]  op;
  logic        stall, done, busy;
  logic [31:0] perf;
  logic        ev1, fl1;
  logic [4:0]  op1;
  logic        stall1, done1, busy1;
  logic [31:0] perf1;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_perf;

  always #5 clk = ~clk;

  mdu_stall_ctrl dut (
    .ACLK(clk), .RESET(rst), .ex_valid(ev), .aluop(op), .flush(fl),
    .stall(stall), .mdu_done(done), .busy(busy), .perf_stall_cnt(perf)
  );

  mdu_stall_ctrl #(.MUL_LATENCY(1)) dut1 (
    .ACLK(clk), .RESET(rst), .ex_valid(ev1), .aluop(op1), .flush(fl1),
    .stall(stall1), .mdu_done(done1), .busy(busy1), .perf_stall_cnt(perf1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue an M-op on the default DUT and follow it cycle by cycle to DONE.
  task automatic run_op(input logic [4:0] opc, input int lat, input bit chain,
                        input logic [4:0] next_op);
    ev = 1'b1;
    op = opc;
    fl = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check_val("op_stall", {31'd0, stall}, 32'd1);
      check_val("op_done_low", {31'd0, done}, 32'd0);
      check_val("op_busy", {31'd0, busy}, (i == 0) ? 32'd0 : 32'd1);
      tick;
    end
    exp_perf = exp_perf + 32'(lat);
    if (chain) begin
      op = next_op;
    end else begin
      ev = 1'b0;
    end
    @(negedge clk);
    check_val("done_pulse", {31'd0, done}, 32'd1);
    check_val("done_stall", {31'd0, stall}, 32'd0);
    check_val("done_busy", {31'd0, busy}, 32'd1);
    tick;
    if (!chain) begin
      @(negedge clk);
      check_val("after_busy", {31'd0, busy}, 32'd0);
      check_val("after_done", {31'd0, done}, 32'd0);
      check_val("after_stall", {31'd0, stall}, 32'd0);
      check_val("after_perf", perf, exp_perf);
    end
  endtask

  // Issue a MUL on the latency-1 DUT: stall only in the accept cycle.
  task automatic run_mul1(input logic [31:0] exp_cnt);
    ev1 = 1'b1;
    op1 = 5'd11;
    @(negedge clk);
    check_val("l1_stall", {31'd0, stall1}, 32'd1);
    check_val("l1_busy0", {31'd0, busy1}, 32'd0);
    tick;
    ev1 = 1'b0;
    @(negedge clk);
    check_val("l1_done", {31'd0, done1}, 32'd1);
    check_val("l1_stall_done", {31'd0, stall1}, 32'd0);
    check_val("l1_perf", perf1, exp_cnt);
    tick;
    @(negedge clk);
    check_val("l1_idle", {31'd0, busy1}, 32'd0);
    tick;
  endtask

  initial begin
    rst = 1'b1;
    ev = 1'b0; fl = 1'b0; op = 5'd0;
    ev1 = 1'b0; fl1 = 1'b0; op1 = 5'd0;
    exp_perf = 32'd0;
    @(negedge clk);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_perf", perf, 32'd0);
    rst = 1'b0;
    tick;

    // MUL, latency 2
    run_op(5'd10, 2, 1'b0, 5'd0);
    tick;

    // DIV, latency 8
    run_op(5'd14, 8, 1'b0, 5'd0);
    tick;

    // single-cycle ops and an M-op without ex_valid never stall
    ev = 1'b1; op = 5'd0;
    @(negedge clk);
    check_val("add_stall", {31'd0, stall}, 32'd0);
    tick;
    op = 5'd18;
    @(negedge clk);
    check_val("op18_stall", {31'd0, stall}, 32'd0);
    tick;
    op = 5'd9;
    @(negedge clk);
    check_val("op9_stall", {31'd0, stall}, 32'd0);
    tick;
    ev = 1'b0; op = 5'd10;
    @(negedge clk);
    check_val("noval_stall", {31'd0, stall}, 32'd0);
    tick;
    @(negedge clk);
    check_val("single_busy", {31'd0, busy}, 32'd0);
    check_val("single_done", {31'd0, done}, 32'd0);
    check_val("single_perf", perf, exp_perf);
    tick;

    // back-to-back MULHU then REM, REM starts the cycle after DONE
    run_op(5'd12, 2, 1'b1, 5'd16);
    run_op(5'd16, 8, 1'b0, 5'd0);
    tick;

    // DIV flushed in its fourth cycle
    ev = 1'b1; op = 5'd14;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("fl_pre_stall", {31'd0, stall}, 32'd1);
      tick;
    end
    fl = 1'b1;
    @(negedge clk);
    check_val("fl_stall", {31'd0, stall}, 32'd0);
    check_val("fl_done", {31'd0, done}, 32'd0);
    check_val("fl_busy", {31'd0, busy}, 32'd1);
    tick;
    fl = 1'b0; ev = 1'b0;
    exp_perf = exp_perf + 32'd3;
    @(negedge clk);
    check_val("fl_idle", {31'd0, busy}, 32'd0);
    check_val("fl_perf", perf, exp_perf);
    for (int i = 0; i < 8; i++) begin
      check_val("fl_no_done", {31'd0, done}, 32'd0);
      tick;
      @(negedge clk);
    end
    tick;

    // asynchronous reset in the middle of a DIV
    ev = 1'b1; op = 5'd14;
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1; ev = 1'b0;
    #1;
    check_val("mid_rst_stall", {31'd0, stall}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_done", {31'd0, done}, 32'd0);
    check_val("mid_rst_perf", perf, 32'd0);
    exp_perf = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    tick;
    run_op(5'd13, 2, 1'b0, 5'd0);
    tick;

    // latency-1 build, counter preloaded just below wrap
    @(negedge clk);
    force dut1.perf_stall_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut1.perf_stall_cnt_r;
    tick;
    run_mul1(32'hFFFF_FFFF);
    run_mul1(32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
